spi_main_arbiter: RTL and testbench
===================================

Name: spi_main_arbiter

Overview:
- SPI Mode 0 (CPOL = CPHA = 0) main controller that drives the sensor-side SPI bus (mosi, miso, sclk, active-low cs) of the tag.
- Shares the single SPI secondary between two on-chip requesters (e.g. tag control FSM and sensor poller) using round-robin arbitration.
- Sequences one full-duplex DATA_W-bit frame per grant, including cs setup, hold and idle gap, then returns the received word.

Parameters:
- DATA_W, 16, bits per frame, shifted MSB first; must be >= 2.
- CLK_DIV, 4, clk cycles per sclk half-period; must be >= 1.
- CS_SETUP, 2, clk cycles between cs falling and the first sclk rising edge; must be >= 1.
- CS_HOLD, 2, clk cycles between the last sclk falling edge and cs rising; must be >= 1.
- CS_IDLE, 2, minimum clk cycles cs stays high between frames; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  per-requester level request; bit i belongs to requester i.
- wdata0  input  DATA_W  transmit word for requester 0; sampled at grant.
- wdata1  input  DATA_W  transmit word for requester 1; sampled at grant.
- gnt  output  2  one-hot grant; high from the grant cycle through the done cycle.
- done  output  2  one-cycle pulse to the granted requester when its frame completes.
- rdata  output  DATA_W  received word; valid from the done pulse until the next done.
- busy  output  1  high in every state except IDLE.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- sclk  output  1  serial clock; idles low.
- cs  output  1  active-low chip select.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - cs = 1, sclk = 0, mosi = 0, gnt = 0, done = 0, rdata = 0, busy = 0, state = IDLE.
  - Round-robin last-served pointer = 1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. All outputs are registered.
- IDLE:
  - If any req bit is high, grant in that cycle's edge: set gnt, latch the corresponding wdata into the shift register, go to SETUP.
  - If both bits are high, grant the requester that was not last served, then update the pointer.
- SETUP:
  - cs = 0 and mosi = MSB of the latched word, for CS_SETUP cycles.
- SHIFT:
  - DATA_W bit periods. Each period is CLK_DIV cycles with sclk = 1 followed by CLK_DIV cycles with sclk = 0.
  - On the clk edge that raises sclk, sample miso into the receive register LSB, shifting it left.
  - On the clk edge that lowers sclk, advance mosi to the next bit.
  - After the final falling edge, mosi holds its last bit.
- HOLD:
  - cs = 0, sclk = 0 for CS_HOLD cycles.
- GAP:
  - cs = 1 for CS_IDLE cycles.
  - In the first GAP cycle: done[i] = 1 for the granted requester, rdata = receive register, gnt cleared in the following cycle.
  - Then return to IDLE.
- Total time cs is low: CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD cycles. There are exactly DATA_W sclk rising edges per frame.
- Minimum spacing between frames: the earliest next cs fall is CS_IDLE + 1 cycles after cs rises (one IDLE cycle for arbitration).
- A requester dropping req mid-frame does not abort the frame; done is still pulsed.
- req changes during a frame are ignored until IDLE. wdata changes after grant have no effect.
- Reset asserted mid-frame:
  - cs rises immediately and no done is issued.
  - After release, pending requests are re-arbitrated from the reset pointer.
- A requester holding req high continuously while the other also requests is served alternately. A requester holding req high alone is served back-to-back.

Test Plan:
- Loopback (miso tied to mosi), req = 2'b01, wdata0 = 16'hA5C3, defaults -> gnt = 2'b01, 16 sclk rising edges, cs low exactly 132 cycles, done = 2'b01 for one cycle, rdata = 16'hA5C3.
- miso held at 1, req = 2'b10, wdata1 = 16'h0000 -> mosi stays 0 throughout, rdata = 16'hFFFF, done = 2'b10; check mosi changes only on sclk falling edges.
- req = 2'b11 held continuously from reset, wdata0 = 16'h1111, wdata1 = 16'h2222, loopback -> frames served in order 0, 1, 0, 1; rdata sequence 1111, 2222, 1111, 2222; cs high at least CS_IDLE cycles between frames.
- rst_n pulsed low during the 5th bit of a frame -> cs = 1 and sclk = 0 in the same cycle, no done pulse; after release with req = 2'b01, a new complete frame is transferred correctly.
- CLK_DIV = 1, DATA_W = 8, wdata0 = 8'h96, loopback -> sclk period of 2 clk cycles, cs low CS_SETUP + 16 + CS_HOLD = 20 cycles, rdata = 8'h96.
- req0 dropped to 0 during SHIFT -> frame completes, done[0] still pulses, and the next IDLE with req = 2'b00 stays idle with busy = 0.

Source files
------------

// File: rtl/spi_main_arbiter.sv
// spi_main_arbiter
//   SPI mode 0 (CPOL = CPHA = 0) main controller shared by two on-chip
//   requesters with round-robin arbitration. Each grant runs one full-duplex
//   DATA_W-bit frame (MSB first) with cs setup, hold and idle gap, then
//   returns the received word.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   req[1:0]        per-requester level request
//   wdata0/wdata1   transmit words, sampled at grant
//   gnt[1:0]        one-hot grant, grant cycle through done cycle
//   done[1:0]       one-cycle completion pulse to the granted requester
//   rdata           received word, valid from done until the next done
//   busy            high whenever the controller is not idle
//   mosi, miso      serial data out / in
//   sclk            serial clock, idles low
//   cs              active-low chip select
module spi_main_arbiter #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mosi,
  input  logic              miso,
  output logic              sclk,
  output logic              cs
);

  localparam int unsigned M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned M2   = (M1 > CS_HOLD) ? M1 : CS_HOLD;
  localparam int unsigned MAXC = (M2 > CS_IDLE) ? M2 : CS_IDLE;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned BW   = $clog2(DATA_W);

  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LD  = CW'(CS_IDLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-2:0] sreg;   // bits still to be sent; MSB goes straight to mosi
  logic [DATA_W-1:0] rx;
  logic              last;   // requester served most recently
  logic              pick;
  logic [DATA_W-1:0] wsel;

  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last;
    wsel = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sreg   <= '0;
      rx     <= '0;
      last   <= 1'b1;
      gnt    <= '0;
      done   <= '0;
      rdata  <= '0;
      busy   <= 1'b0;
      mosi   <= 1'b0;
      sclk   <= 1'b0;
      cs     <= 1'b1;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= {pick, ~pick};
            last  <= pick;
            mosi  <= wsel[DATA_W-1];
            sreg  <= wsel[DATA_W-2:0];
            cs    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            sclk   <= 1'b1;
            rx     <= {rx[DATA_W-2:0], miso};
            bitcnt <= '0;
            cnt    <= DIV_LD;
            state  <= SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (sclk) begin
            // falling edge: advance mosi, except after the final bit
            sclk <= 1'b0;
            cnt  <= DIV_LD;
            if (bitcnt != LAST_BIT) begin
              mosi <= sreg[DATA_W-2];
              sreg <= sreg << 1;
            end
          end else if (bitcnt == LAST_BIT) begin
            // final low half-period has elapsed
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            sclk   <= 1'b1;
            rx     <= {rx[DATA_W-2:0], miso};
            bitcnt <= bitcnt + 1'b1;
            cnt    <= DIV_LD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs    <= 1'b1;
            done  <= gnt;
            rdata <= rx;
            cnt   <= IDLE_LD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          gnt <= '0;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_main_arbiter.sv
module tb_spi_main_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;

  // instance A: default geometry
  logic [1:0]  req_a;
  logic [15:0] wdata0_a, wdata1_a;
  logic [1:0]  gnt_a, done_a;
  logic [15:0] rdata_a;
  logic        busy_a, mosi_a, miso_a, sclk_a, cs_a;
  logic        loop_a;
  logic        miso_fix;

  // instance B: DATA_W = 8, CLK_DIV = 1, always looped back
  logic [1:0]  req_b;
  logic [7:0]  wdata0_b, wdata1_b;
  logic [1:0]  gnt_b, done_b;
  logic [7:0]  rdata_b;
  logic        busy_b, mosi_b, miso_b, sclk_b, cs_b;

  assign miso_a = loop_a ? mosi_a : miso_fix;
  assign miso_b = mosi_b;

  always #5 clk = ~clk;

  spi_main_arbiter #(.DATA_W(16), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
    .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a),
    .mosi(mosi_a), .miso(miso_a), .sclk(sclk_a), .cs(cs_a)
  );

  spi_main_arbiter #(.DATA_W(8), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b),
    .mosi(mosi_b), .miso(miso_b), .sclk(sclk_b), .cs(cs_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs_low_a(input string tag);
    int n;
    n = 0;
    while (cs_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cs_fall"}, {31'd0, cs_a}, 32'd0);
  endtask

  // Runs one frame on instance A from cs fall (or the current cs-low sample)
  // to one cycle after done. gap returns the number of cs-high samples seen
  // before the fall.
  task automatic frame_a(input string tag, input logic [1:0] egnt, input logic [15:0] erd,
                         input int ecslow, input int erises, input bit chkzero,
                         input bit drop, output int gap);
    int   n, cslow, rises, badm, nz;
    logic ps, pm;
    n = 0; cslow = 0; rises = 0; badm = 0; nz = 0;
    while (cs_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    check({tag, "_cs_fall"}, {31'd0, cs_a}, 32'd0);
    if (drop) req_a = 2'b00;
    check({tag, "_gnt"}, {30'd0, gnt_a}, {30'd0, egnt});
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
    ps = sclk_a;
    pm = mosi_a;
    while (cs_a === 1'b0 && cslow < 400) begin
      cslow++;
      if (sclk_a && !ps) rises++;
      if (mosi_a !== pm && !(ps && !sclk_a)) badm++;
      if (mosi_a !== 1'b0) nz++;
      ps = sclk_a;
      pm = mosi_a;
      @(negedge clk);
    end
    if (ecslow >= 0) check({tag, "_cs_low_cycles"}, cslow, ecslow);
    if (erises >= 0) check({tag, "_sclk_rises"}, rises, erises);
    check({tag, "_mosi_off_fall"}, badm, 0);
    if (chkzero) check({tag, "_mosi_nonzero"}, nz, 0);
    check({tag, "_done"}, {30'd0, done_a}, {30'd0, egnt});
    check({tag, "_rdata"}, {16'd0, rdata_a}, {16'd0, erd});
    @(negedge clk);
    check({tag, "_done_1cyc"}, {30'd0, done_a}, 32'd0);
    check({tag, "_gnt_clr"}, {30'd0, gnt_a}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int cslow, rises, highs, n;
    logic ps;

    rst_n = 1'b0;
    req_a = 2'b00; wdata0_a = '0; wdata1_a = '0; loop_a = 1'b1; miso_fix = 1'b0;
    req_b = 2'b00; wdata0_b = '0; wdata1_b = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_cs", {31'd0, cs_a}, 32'd1);
    check("rst_sclk", {31'd0, sclk_a}, 32'd0);
    check("rst_mosi", {31'd0, mosi_a}, 32'd0);
    check("rst_gnt", {30'd0, gnt_a}, 32'd0);
    check("rst_done", {30'd0, done_a}, 32'd0);
    check("rst_rdata", {16'd0, rdata_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_b_cs", {31'd0, cs_b}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy_a}, 32'd0);

    // loopback, requester 0
    wdata0_a = 16'hA5C3;
    req_a = 2'b01;
    frame_a("lb0", 2'b01, 16'hA5C3, 132, 16, 1'b0, 1'b1, g);

    // miso stuck high, requester 1 sends zeros
    loop_a = 1'b0; miso_fix = 1'b1;
    wdata1_a = 16'h0000;
    req_a = 2'b10;
    frame_a("ones1", 2'b10, 16'hFFFF, 132, 16, 1'b1, 1'b1, g);
    loop_a = 1'b1;

    // requester 0 drops req mid-shift; frame still completes
    wdata0_a = 16'h3C5A;
    req_a = 2'b01;
    wait_cs_low_a("drop");
    repeat (30) @(negedge clk);
    req_a = 2'b00;
    wdata0_a = 16'hFFFF;  // post-grant change must not matter
    frame_a("drop", 2'b01, 16'h3C5A, -1, -1, 1'b0, 1'b0, g);
    repeat (5) @(negedge clk);
    check("drop_idle_busy", {31'd0, busy_a}, 32'd0);
    check("drop_idle_cs", {31'd0, cs_a}, 32'd1);
    check("drop_idle_gnt", {30'd0, gnt_a}, 32'd0);

    // both requesting from reset: alternate 0,1,0,1
    rst_n = 1'b0;
    req_a = 2'b11; wdata0_a = 16'h1111; wdata1_a = 16'h2222;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame_a("rr0", 2'b01, 16'h1111, 132, 16, 1'b0, 1'b0, g);
    frame_a("rr1", 2'b10, 16'h2222, 132, 16, 1'b0, 1'b0, g);
    // cs high samples = CS_IDLE GAP cycles + 1 IDLE cycle; one already consumed
    check("rr1_gap", g + 1, 3);
    frame_a("rr2", 2'b01, 16'h1111, 132, 16, 1'b0, 1'b0, g);
    check("rr2_gap", g + 1, 3);
    frame_a("rr3", 2'b10, 16'h2222, 132, 16, 1'b0, 1'b0, g);
    check("rr3_gap", g + 1, 3);
    req_a = 2'b00;

    // reset during the 5th bit (sclk high at sample 36 after cs fall)
    wdata0_a = 16'hF0F0;
    req_a = 2'b01;
    repeat (4) @(negedge clk);
    wait_cs_low_a("rstmid");
    repeat (35) @(negedge clk);
    check("rstmid_pre_sclk", {31'd0, sclk_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_cs", {31'd0, cs_a}, 32'd1);
    check("rstmid_sclk", {31'd0, sclk_a}, 32'd0);
    check("rstmid_done", {30'd0, done_a}, 32'd0);
    check("rstmid_gnt", {30'd0, gnt_a}, 32'd0);
    @(negedge clk);
    check("rstmid_done2", {30'd0, done_a}, 32'd0);
    wdata0_a = 16'h1234;
    rst_n = 1'b1;
    frame_a("after_rst", 2'b01, 16'h1234, 132, 16, 1'b0, 1'b1, g);

    // instance B: 8-bit frame, sclk period of 2 clk cycles
    wdata0_b = 8'h96;
    req_b = 2'b01;
    n = 0;
    while (cs_b !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_cs_fall", {31'd0, cs_b}, 32'd0);
    req_b = 2'b00;
    cslow = 0; rises = 0; highs = 0;
    ps = sclk_b;
    while (cs_b === 1'b0 && cslow < 100) begin
      cslow++;
      if (sclk_b && !ps) rises++;
      if (sclk_b) highs++;
      ps = sclk_b;
      @(negedge clk);
    end
    check("b_cs_low_cycles", cslow, 20);
    check("b_sclk_rises", rises, 8);
    check("b_sclk_high_cycles", highs, 8);
    check("b_done", {30'd0, done_b}, 32'd1);
    check("b_rdata", {24'd0, rdata_b}, 32'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
